// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: holds the architectural PC, fetches the instruction at that PC
// over a request/grant/response handshake, presents it to decode, and advances
// to the next-PC value when the datapath retires it. Also keeps a wrapping
// retired-instruction counter and a sticky misaligned-target fault.
module pc_fetch_unit #(
  parameter logic [63:0] RESETPC = 64'h0
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [63:0] NextPC,
  input  logic        InstrRetire,
  input  logic        IMemGnt,
  input  logic        IMemRdValid,
  input  logic [31:0] IMemRdData,
  output logic [63:0] CurrentPC,
  output logic        IMemReq,
  output logic [63:0] IMemAddr,
  output logic [31:0] Instruction,
  output logic        InstrValid,
  output logic [31:0] InstrCount,
  output logic        Fault
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    EXEC,
    FAULT
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [63:0] r_currentPc;
  logic [31:0] r_instruction;
  logic [31:0] r_instrCount;

  logic        w_retire;
  logic        w_aligned;
  logic        w_capture;

  // Inputs only matter in the one state that listens to them; everything
  // else is gated off here so stray strobes cannot leak into state.
  assign w_retire  = (r_state == EXEC) && InstrRetire;
  assign w_aligned = (NextPC[1:0] == 2'b00);
  assign w_capture = (r_state == WAIT) && IMemRdValid;

  // State register; reset forces IDLE immediately regardless of the clock.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode for the fetch/execute handshake sequence.
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE:    w_nextState = FETCH;
      FETCH:   if (IMemGnt) w_nextState = WAIT;
      WAIT:    if (IMemRdValid) w_nextState = EXEC;
      EXEC:    if (InstrRetire) w_nextState = w_aligned ? FETCH : FAULT;
      FAULT:   w_nextState = FAULT;
      default: w_nextState = IDLE;
    endcase
  end

  // Strobes are pure decodes of the registered state so they are glitch-free
  // and read as inactive while reset is held.
  always_comb begin
    IMemReq    = 1'b0;
    InstrValid = 1'b0;
    Fault      = 1'b0;
    unique case (r_state)
      FETCH:   IMemReq    = 1'b1;
      EXEC:    InstrValid = 1'b1;
      FAULT:   Fault      = 1'b1;
      default: ;
    endcase
  end

  // PC and retire counter advance together on an aligned retire only; a
  // misaligned target leaves both untouched and the FSM parks in FAULT.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_currentPc  <= RESETPC;
      r_instrCount <= 32'd0;
    end else if (w_retire && w_aligned) begin
      r_currentPc  <= NextPC;
      r_instrCount <= r_instrCount + 32'd1;
    end
  end

  // Instruction word is captured only from a response seen while waiting,
  // and otherwise holds its last value.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_instruction <= 32'd0;
    end else if (w_capture) begin
      r_instruction <= IMemRdData;
    end
  end

  assign CurrentPC   = r_currentPc;
  assign IMemAddr    = r_currentPc;
  assign Instruction = r_instruction;
  assign InstrCount  = r_instrCount;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed scenarios for pc_fetch_unit. Inputs are driven
// and outputs sampled on the falling clock edge, away from the active edge.
module tb_pc_fetch_unit;

  localparam logic [63:0] RESETPC = 64'h0;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [63:0] NextPC;
  logic        InstrRetire;
  logic        IMemGnt;
  logic        IMemRdValid;
  logic [31:0] IMemRdData;
  logic [63:0] CurrentPC;
  logic        IMemReq;
  logic [63:0] IMemAddr;
  logic [31:0] Instruction;
  logic        InstrValid;
  logic [31:0] InstrCount;
  logic        Fault;

  int checkCount = 0;
  int passCount  = 0;

  pc_fetch_unit #(.RESETPC(RESETPC)) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .NextPC     (NextPC),
    .InstrRetire(InstrRetire),
    .IMemGnt    (IMemGnt),
    .IMemRdValid(IMemRdValid),
    .IMemRdData (IMemRdData),
    .CurrentPC  (CurrentPC),
    .IMemReq    (IMemReq),
    .IMemAddr   (IMemAddr),
    .Instruction(Instruction),
    .InstrValid (InstrValid),
    .InstrCount (InstrCount),
    .Fault      (Fault)
  );

  // Free-running 10-unit clock.
  always #5 CLK = ~CLK;

  task automatic tick();
    @(negedge CLK);
  endtask

  // One full zero-wait instruction from FETCH back to FETCH (stimulus only).
  task automatic fetch_instr(input logic [31:0] data, input logic [63:0] next);
    IMemGnt = 1'b1;
    tick();
    IMemGnt = 1'b0;
    IMemRdValid = 1'b1;
    IMemRdData = data;
    tick();
    IMemRdValid = 1'b0;
    InstrRetire = 1'b1;
    NextPC = next;
    tick();
    InstrRetire = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    NextPC = 64'h0;
    InstrRetire = 1'b0;
    IMemGnt = 1'b0;
    IMemRdValid = 1'b0;
    IMemRdData = 32'h0;
    tick();
    tick();
    checkCount++;
    if (CurrentPC !== RESETPC) $display("[TB] FAIL reset_pc: got %h want %h", CurrentPC, RESETPC);
    else passCount++;
    checkCount++;
    if ({IMemReq, InstrValid, Fault} !== 3'b000) $display("[TB] FAIL reset_strobes: got %b want 000", {IMemReq, InstrValid, Fault});
    else passCount++;
    checkCount++;
    if (Instruction !== 32'h0 || InstrCount !== 32'h0) $display("[TB] FAIL reset_regs: got instr %h count %0d want 0 0", Instruction, InstrCount);
    else passCount++;
    Reset = 1'b0;
    checkCount++;
    if (IMemReq !== 1'b0) $display("[TB] FAIL idle_req: got %b want 0", IMemReq);
    else passCount++;
    tick();
    checkCount++;
    if (IMemReq !== 1'b1 || IMemAddr !== RESETPC) $display("[TB] FAIL idle_one_cycle: got req %b addr %h want 1 %h", IMemReq, IMemAddr, RESETPC);
    else passCount++;
  endtask

  task automatic test_sequential();
    logic [63:0] addr;
    logic [31:0] word;
    for (int i = 0; i < 4; i++) begin
      addr = 64'(i * 4);
      word = 32'hA0000000 + addr[31:0];
      checkCount++;
      if (IMemReq !== 1'b1 || IMemAddr !== addr) $display("[TB] FAIL seq_fetch%0d: got req %b addr %h want 1 %h", i, IMemReq, IMemAddr, addr);
      else passCount++;
      IMemGnt = 1'b1;
      tick();
      IMemGnt = 1'b0;
      IMemRdValid = 1'b1;
      IMemRdData = word;
      tick();
      IMemRdValid = 1'b0;
      checkCount++;
      if (InstrValid !== 1'b1 || Instruction !== word) $display("[TB] FAIL seq_exec%0d: got valid %b instr %h want 1 %h", i, InstrValid, Instruction, word);
      else passCount++;
      InstrRetire = 1'b1;
      NextPC = addr + 64'd4;
      tick();
      InstrRetire = 1'b0;
      checkCount++;
      if (CurrentPC !== addr + 64'd4 || InstrValid !== 1'b0) $display("[TB] FAIL seq_retire%0d: got pc %h valid %b want %h 0", i, CurrentPC, InstrValid, addr + 64'd4);
      else passCount++;
    end
    checkCount++;
    if (InstrCount !== 32'd4 || IMemReq !== 1'b1 || IMemAddr !== 64'd16) $display("[TB] FAIL seq_count: got count %0d req %b addr %h want 4 1 10", InstrCount, IMemReq, IMemAddr);
    else passCount++;
  endtask

  task automatic test_branch();
    fetch_instr(32'hB0000010, 64'd20);
    checkCount++;
    if (InstrCount !== 32'd5 || IMemAddr !== 64'd20) $display("[TB] FAIL br_pre: got count %0d addr %h want 5 14", InstrCount, IMemAddr);
    else passCount++;
    fetch_instr(32'hB0000014, 64'h100);
    checkCount++;
    if (IMemReq !== 1'b1 || IMemAddr !== 64'h100 || CurrentPC !== 64'h100) $display("[TB] FAIL br_target: got req %b addr %h pc %h want 1 100 100", IMemReq, IMemAddr, CurrentPC);
    else passCount++;
    checkCount++;
    if (InstrCount !== 32'd6) $display("[TB] FAIL br_count: got %0d want 6", InstrCount);
    else passCount++;
  endtask

  task automatic test_stalls();
    logic stable;
    int   validCycles;
    stable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (IMemReq !== 1'b1 || IMemAddr !== 64'h100) stable = 1'b0;
      tick();
    end
    checkCount++;
    if (stable !== 1'b1 || IMemReq !== 1'b1 || IMemAddr !== 64'h100) $display("[TB] FAIL stall_req_hold: got req %b addr %h want 1 100", IMemReq, IMemAddr);
    else passCount++;
    IMemGnt = 1'b1;
    tick();
    IMemGnt = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (IMemReq !== 1'b0 || InstrValid !== 1'b0) stable = 1'b0;
      tick();
    end
    checkCount++;
    if (stable !== 1'b1) $display("[TB] FAIL stall_wait: got req/valid active during wait want both 0");
    else passCount++;
    IMemRdValid = 1'b1;
    IMemRdData = 32'hDEADBEEF;
    tick();
    IMemRdValid = 1'b0;
    IMemRdData = 32'h0;
    validCycles = 0;
    for (int i = 0; i < 20; i++) begin
      if (InstrValid !== 1'b1) break;
      validCycles++;
      InstrRetire = (validCycles == 5);
      NextPC = 64'h104;
      tick();
    end
    InstrRetire = 1'b0;
    checkCount++;
    if (validCycles != 5) $display("[TB] FAIL stall_valid_len: got %0d cycles want 5", validCycles);
    else passCount++;
    checkCount++;
    if (Instruction !== 32'hDEADBEEF || CurrentPC !== 64'h104) $display("[TB] FAIL stall_data: got instr %h pc %h want deadbeef 104", Instruction, CurrentPC);
    else passCount++;
  endtask

  task automatic test_spurious();
    IMemRdValid = 1'b1;
    IMemRdData = 32'h11111111;
    tick();
    IMemGnt = 1'b1;
    tick();
    IMemGnt = 1'b0;
    IMemRdValid = 1'b0;
    checkCount++;
    if (Instruction !== 32'hDEADBEEF || IMemReq !== 1'b0) $display("[TB] FAIL spur_fetch_rd: got instr %h req %b want deadbeef 0", Instruction, IMemReq);
    else passCount++;
    InstrRetire = 1'b1;
    NextPC = 64'h200;
    tick();
    InstrRetire = 1'b0;
    checkCount++;
    if (CurrentPC !== 64'h104 || InstrCount !== 32'd7 || InstrValid !== 1'b0) $display("[TB] FAIL spur_wait_retire: got pc %h count %0d valid %b want 104 7 0", CurrentPC, InstrCount, InstrValid);
    else passCount++;
    IMemRdValid = 1'b1;
    IMemRdData = 32'h22222222;
    tick();
    IMemRdData = 32'h33333333;
    tick();
    IMemRdValid = 1'b0;
    checkCount++;
    if (Instruction !== 32'h22222222 || InstrValid !== 1'b1) $display("[TB] FAIL spur_exec_rd: got instr %h valid %b want 22222222 1", Instruction, InstrValid);
    else passCount++;
    InstrRetire = 1'b1;
    NextPC = 64'h108;
    tick();
    InstrRetire = 1'b0;
    checkCount++;
    if (InstrCount !== 32'd8 || CurrentPC !== 64'h108) $display("[TB] FAIL spur_retire: got count %0d pc %h want 8 108", InstrCount, CurrentPC);
    else passCount++;
  endtask

  task automatic test_misaligned();
    logic reqSeen;
    IMemGnt = 1'b1;
    tick();
    IMemGnt = 1'b0;
    IMemRdValid = 1'b1;
    IMemRdData = 32'h44444444;
    tick();
    IMemRdValid = 1'b0;
    InstrRetire = 1'b1;
    NextPC = 64'h102;
    tick();
    InstrRetire = 1'b0;
    checkCount++;
    if (Fault !== 1'b1 || CurrentPC !== 64'h108 || InstrCount !== 32'd8) $display("[TB] FAIL mis_fault: got fault %b pc %h count %0d want 1 108 8", Fault, CurrentPC, InstrCount);
    else passCount++;
    reqSeen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      IMemGnt = i[0];
      IMemRdValid = i[1];
      InstrRetire = i[2];
      NextPC = 64'h300;
      if (IMemReq !== 1'b0 || InstrValid !== 1'b0) reqSeen = 1'b1;
      tick();
    end
    IMemGnt = 1'b0;
    IMemRdValid = 1'b0;
    InstrRetire = 1'b0;
    checkCount++;
    if (reqSeen !== 1'b0 || Fault !== 1'b1 || CurrentPC !== 64'h108) $display("[TB] FAIL mis_park: got strobe_seen %b fault %b pc %h want 0 1 108", reqSeen, Fault, CurrentPC);
    else passCount++;
    Reset = 1'b1;
    tick();
    checkCount++;
    if (Fault !== 1'b0 || CurrentPC !== RESETPC || InstrCount !== 32'd0) $display("[TB] FAIL mis_reset: got fault %b pc %h count %0d want 0 %h 0", Fault, CurrentPC, InstrCount, RESETPC);
    else passCount++;
    Reset = 1'b0;
    tick();
    checkCount++;
    if (IMemReq !== 1'b1 || IMemAddr !== RESETPC) $display("[TB] FAIL mis_restart: got req %b addr %h want 1 %h", IMemReq, IMemAddr, RESETPC);
    else passCount++;
  endtask

  task automatic test_async_reset();
    fetch_instr(32'h12345678, 64'h40);
    IMemGnt = 1'b1;
    tick();
    IMemGnt = 1'b0;
    #2;
    Reset = 1'b1;
    #1;
    checkCount++;
    if (CurrentPC !== RESETPC || Instruction !== 32'h0 || InstrCount !== 32'h0) $display("[TB] FAIL areset_regs: got pc %h instr %h count %0d want %h 0 0", CurrentPC, Instruction, InstrCount, RESETPC);
    else passCount++;
    checkCount++;
    if ({IMemReq, InstrValid, Fault} !== 3'b000) $display("[TB] FAIL areset_strobes: got %b want 000", {IMemReq, InstrValid, Fault});
    else passCount++;
    tick();
    Reset = 1'b0;
    IMemRdValid = 1'b1;
    IMemRdData = 32'h5555AAAA;
    tick();
    checkCount++;
    if (Instruction !== 32'h0 || IMemReq !== 1'b1 || IMemAddr !== RESETPC) $display("[TB] FAIL areset_late_rd: got instr %h req %b addr %h want 0 1 %h", Instruction, IMemReq, IMemAddr, RESETPC);
    else passCount++;
    tick();
    IMemRdValid = 1'b0;
    checkCount++;
    if (Instruction !== 32'h0 || IMemReq !== 1'b1) $display("[TB] FAIL areset_fetch_hold: got instr %h req %b want 0 1", Instruction, IMemReq);
    else passCount++;
  endtask

  task automatic test_wrap();
    IMemGnt = 1'b1;
    tick();
    IMemGnt = 1'b0;
    IMemRdValid = 1'b1;
    IMemRdData = 32'h9ABCDEF0;
    tick();
    IMemRdValid = 1'b0;
    force dut.r_instrCount = 32'hFFFFFFFF;
    #1;
    release dut.r_instrCount;
    checkCount++;
    if (InstrCount !== 32'hFFFFFFFF || InstrValid !== 1'b1) $display("[TB] FAIL wrap_preload: got count %h valid %b want ffffffff 1", InstrCount, InstrValid);
    else passCount++;
    InstrRetire = 1'b1;
    NextPC = 64'h4;
    tick();
    InstrRetire = 1'b0;
    checkCount++;
    if (InstrCount !== 32'h0 || Fault !== 1'b0 || CurrentPC !== 64'h4) $display("[TB] FAIL wrap_count: got count %h fault %b pc %h want 0 0 4", InstrCount, Fault, CurrentPC);
    else passCount++;
  endtask

  // Scenario sequence and summary.
  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_stalls();
    test_spurious();
    test_misaligned();
    test_async_reset();
    test_wrap();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL timeout: got no finish want finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
